// File: rtl/ex_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_pkg
// Description : Shared width, funct codes, FSM states and helpers for the
//               EX-stage multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_muldiv_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] c_FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] c_FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] c_FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] c_FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] c_FUNCT_MULT  = 6'h18;
    localparam logic [5:0] c_FUNCT_MULTU = 6'h19;
    localparam logic [5:0] c_FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] c_FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] funct);
        return (funct == c_FUNCT_MULT) || (funct == c_FUNCT_MULTU) ||
               (funct == c_FUNCT_DIV)  || (funct == c_FUNCT_DIVU);
    endfunction

    // Two's-complement negate when cond is set; used for magnitudes and sign fix-up.
    function automatic logic [DATA_W-1:0] neg_if(input logic cond, input logic [DATA_W-1:0] v);
        return cond ? (~v + 1'b1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_if
// Description : EX-stage signals between the pipeline and the mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic              valid;
    logic [5:0]        funct;
    logic [DATA_W-1:0] operand_1;
    logic [DATA_W-1:0] operand_2;
    logic              ex_stall;
    logic              flush;
    logic              stall_request;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output valid, funct, operand_1, operand_2, ex_stall, flush,
        input  stall_request, result, hi, lo
    );

    modport slave (
        input  valid, funct, operand_1, operand_2, ex_stall, flush,
        output stall_request, result, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : 32-step restoring divider on unsigned magnitudes, one step
//               per cycle. quotient_o/remainder_o show the post-step values.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import ex_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    logic [DATA_W:0]   w_shift;
    logic [DATA_W+1:0] w_diff;
    logic              w_ge;

    // Extra guard bit keeps a zero divisor from looking negative once the
    // partial remainder's top bit is set.
    assign w_shift = {rem_q, quo_q[DATA_W-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, dvs_q};
    assign w_ge    = ~w_diff[DATA_W+1];
    assign rem_d   = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign quo_d   = {quo_q[DATA_W-2:0], w_ge};

    assign busy_o      = busy_q;
    assign done_o      = busy_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign quotient_o  = quo_d;
    assign remainder_o = rem_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvs_q  <= divisor_i;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : EX-stage multiply/divide unit owning HI/LO; 2-cycle multiply,
//               33-cycle iterative divide, MFHI/MFLO/MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    state_t            state_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic              sgn_q;
    logic [DATA_W-1:0] res_hi_q, res_lo_q;
    logic [DATA_W-1:0] hi_q, lo_q;

    logic                w_md_funct, w_is_div, w_is_signed, w_start;
    logic [2*DATA_W-1:0] w_mul_a, w_mul_b, w_product;
    logic                w_div_busy, w_div_done;
    logic [DATA_W-1:0]   w_div_q, w_div_r, w_quot, w_rem;

    assign w_md_funct  = is_muldiv(bus.funct);
    assign w_is_div    = (bus.funct == c_FUNCT_DIV) || (bus.funct == c_FUNCT_DIVU);
    assign w_is_signed = (bus.funct == c_FUNCT_MULT) || (bus.funct == c_FUNCT_DIV);
    assign w_start     = bus.valid && w_md_funct && !bus.flush && (state_q == S_IDLE);

    assign w_mul_a   = {{DATA_W{sgn_q & op1_q[DATA_W-1]}}, op1_q};
    assign w_mul_b   = {{DATA_W{sgn_q & op2_q[DATA_W-1]}}, op2_q};
    assign w_product = w_mul_a * w_mul_b;

    div_iter u_div_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (w_start && w_is_div),
        .abort_i     (bus.flush),
        .dividend_i  (neg_if(w_is_signed & bus.operand_1[DATA_W-1], bus.operand_1)),
        .divisor_i   (neg_if(w_is_signed & bus.operand_2[DATA_W-1], bus.operand_2)),
        .busy_o      (w_div_busy),
        .done_o      (w_div_done),
        .quotient_o  (w_div_q),
        .remainder_o (w_div_r)
    );

    // Quotient sign follows the XOR of operand signs; remainder follows the dividend.
    assign w_quot = neg_if(sgn_q & (op1_q[DATA_W-1] ^ op2_q[DATA_W-1]), w_div_q);
    assign w_rem  = neg_if(sgn_q & op1_q[DATA_W-1], w_div_r);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            sgn_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else if (bus.flush) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        op1_q   <= bus.operand_1;
                        op2_q   <= bus.operand_2;
                        sgn_q   <= w_is_signed;
                        state_q <= w_is_div ? S_DIV : S_MUL;
                    end else if (bus.valid && !bus.ex_stall) begin
                        if (bus.funct == c_FUNCT_MTHI) hi_q <= bus.operand_1;
                        if (bus.funct == c_FUNCT_MTLO) lo_q <= bus.operand_1;
                    end
                end
                S_MUL: begin
                    {res_hi_q, res_lo_q} <= w_product;
                    state_q              <= S_DONE;
                end
                S_DIV: begin
                    if (w_div_done) begin
                        res_hi_q <= w_rem;
                        res_lo_q <= w_quot;
                        state_q  <= S_DONE;
                    end else if (!w_div_busy) begin
                        // Divider lost its operation; recover rather than hang EX.
                        state_q <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!bus.ex_stall) begin
                        hi_q    <= res_hi_q;
                        lo_q    <= res_lo_q;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_request = bus.valid && w_md_funct && !bus.flush && (state_q != S_DONE);
    assign bus.hi            = hi_q;
    assign bus.lo            = lo_q;

    always_comb begin
        bus.result = '0;
        if (bus.valid) begin
            if (bus.funct == c_FUNCT_MFHI) bus.result = hi_q;
            if (bus.funct == c_FUNCT_MFLO) bus.result = lo_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] model_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'({32'h0, a});
        y = s ? longint'($signed(b)) : longint'({32'h0, b});
        return 64'(x * y);
    endfunction

    task automatic model_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        longint x, y;
        if (b == 32'h0) begin
            q = (s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
            r = a;
        end else begin
            x = s ? longint'($signed(a)) : longint'({32'h0, a});
            y = s ? longint'($signed(b)) : longint'({32'h0, b});
            q = 32'(x / y);
            r = 32'(x % y);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op, count stall cycles (bounded), then take the commit edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        bus.valid = 1'b1; bus.funct = f; bus.operand_1 = a; bus.operand_2 = b;
        #1;
        stalls = 0;
        while (bus.stall_request && stalls < 100) begin
            stalls++;
            tick();
        end
        tick();
        bus.valid = 1'b0; bus.funct = 6'h0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", bus.hi, 32'h0); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", bus.lo, 32'h0); end
        checks++; if (bus.stall_request !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall_request); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    endtask

    task automatic test_mult();
        logic [31:0] a, b;
        logic        s;
        logic [63:0] p;
        int          st;
        for (int i = 0; i < 10; i++) begin
            if (i < 2) begin
                a = 32'hFFFF_FFFE; b = 32'h0000_0003; s = (i == 0);
            end else begin
                a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            end
            p = model_mul(s, a, b);
            issue(s ? MULT : MULTU, a, b, st);
            checks++; if (st !== 2) begin failures++; $display("FAIL mul_stalls[%0d] got=%0d exp=2", i, st); end
            checks++; if (bus.hi !== p[63:32]) begin failures++; $display("FAIL mul_hi[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, bus.hi, p[63:32]); end
            checks++; if (bus.lo !== p[31:0]) begin failures++; $display("FAIL mul_lo[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, bus.lo, p[31:0]); end
            bus.valid = 1'b1; bus.funct = MFHI; #1;
            checks++; if (bus.result !== p[63:32]) begin failures++; $display("FAIL mfhi_after_mul[%0d] got=%h exp=%h", i, bus.result, p[63:32]); end
            bus.funct = MFLO; #1;
            checks++; if (bus.result !== p[31:0]) begin failures++; $display("FAIL mflo_after_mul[%0d] got=%h exp=%h", i, bus.result, p[31:0]); end
            tick();
            bus.valid = 1'b0; bus.funct = 6'h0;
        end
    endtask

    task automatic test_div();
        logic [31:0] a, b, q, r;
        logic        s;
        int          st;
        for (int i = 0; i < 14; i++) begin
            case (i)
                0: begin a = 32'hFFFF_FFF9; b = 32'h2;         s = 1'b1; end
                1: begin a = 32'h7;         b = 32'h2;         s = 1'b0; end
                2: begin a = 32'h1234;      b = 32'h0;         s = 1'b0; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
                4: begin a = 32'hFFFF_FF00; b = 32'h0;         s = 1'b1; end
                default: begin
                    a = $urandom;
                    b = ($urandom_range(0, 7) == 0) ? 32'h0 :
                        ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
                    s = 1'($urandom_range(0, 1));
                end
            endcase
            model_div(s, a, b, q, r);
            issue(s ? DIV : DIVU, a, b, st);
            checks++; if (st !== 33) begin failures++; $display("FAIL div_stalls[%0d] got=%0d exp=33", i, st); end
            checks++; if (bus.lo !== q) begin failures++; $display("FAIL div_lo[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, bus.lo, q); end
            checks++; if (bus.hi !== r) begin failures++; $display("FAIL div_hi[%0d] a=%h b=%h s=%b got=%h exp=%h", i, a, b, s, bus.hi, r); end
        end
    endtask

    task automatic test_flush();
        int st;
        bus.valid = 1'b1; bus.funct = MTHI; bus.operand_1 = 32'hAAAA; tick();
        bus.funct = MTLO; bus.operand_1 = 32'h5555; tick();
        bus.valid = 1'b0; bus.funct = 6'h0; #1;
        checks++; if (bus.hi !== 32'hAAAA) begin failures++; $display("FAIL mthi_pre_flush got=%h exp=%h", bus.hi, 32'hAAAA); end
        checks++; if (bus.lo !== 32'h5555) begin failures++; $display("FAIL mtlo_pre_flush got=%h exp=%h", bus.lo, 32'h5555); end
        bus.valid = 1'b1; bus.funct = DIV; bus.operand_1 = 32'd100; bus.operand_2 = 32'd3;
        repeat (10) tick();
        bus.flush = 1'b1; #1;
        checks++; if (bus.stall_request !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", bus.stall_request); end
        tick();
        bus.flush = 1'b0; bus.valid = 1'b0; bus.funct = 6'h0;
        repeat (40) tick();
        checks++; if (bus.hi !== 32'hAAAA) begin failures++; $display("FAIL flush_hi got=%h exp=%h", bus.hi, 32'hAAAA); end
        checks++; if (bus.lo !== 32'h5555) begin failures++; $display("FAIL flush_lo got=%h exp=%h", bus.lo, 32'h5555); end
        issue(MULTU, 32'd6, 32'd7, st);
        checks++; if (st !== 2) begin failures++; $display("FAIL post_flush_stalls got=%0d exp=2", st); end
        checks++; if (bus.lo !== 32'd42) begin failures++; $display("FAIL post_flush_lo got=%h exp=%h", bus.lo, 32'd42); end
    endtask

    task automatic test_ex_stall_done();
        logic [31:0] a, b, old_hi, old_lo;
        logic [63:0] p;
        int          st;
        a = $urandom; b = $urandom | 32'h1;
        p = model_mul(1'b1, a, b);
        old_hi = 32'h1357; old_lo = 32'h2468;
        bus.valid = 1'b1; bus.funct = MTHI; bus.operand_1 = old_hi; tick();
        bus.funct = MTLO; bus.operand_1 = old_lo; tick();
        bus.funct = MULT; bus.operand_1 = a; bus.operand_2 = b; #1;
        st = 0;
        while (bus.stall_request && st < 100) begin st++; tick(); end
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.stall_request !== 1'b0) begin failures++; $display("FAIL done_hold_stall[%0d] got=%b exp=0", i, bus.stall_request); end
            checks++; if ({bus.hi, bus.lo} !== {old_hi, old_lo}) begin failures++; $display("FAIL done_hold_hilo[%0d] got=%h exp=%h", i, {bus.hi, bus.lo}, {old_hi, old_lo}); end
            tick();
        end
        bus.ex_stall = 1'b0; #1;
        checks++; if ({bus.hi, bus.lo} !== {old_hi, old_lo}) begin failures++; $display("FAIL done_precommit got=%h exp=%h", {bus.hi, bus.lo}, {old_hi, old_lo}); end
        tick();
        bus.valid = 1'b0; bus.funct = 6'h0;
        checks++; if ({bus.hi, bus.lo} !== p) begin failures++; $display("FAIL done_commit got=%h exp=%h", {bus.hi, bus.lo}, p); end
        checks++; if (st !== 2) begin failures++; $display("FAIL done_mul_stalls got=%0d exp=2", st); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, d, q, r;
        logic [63:0] p;
        int          st1, st2;
        a = $urandom; b = $urandom; c = $urandom; d = 32'($urandom_range(1, 50000));
        p = model_mul(1'b0, a, b);
        model_div(1'b0, c, d, q, r);
        bus.valid = 1'b1; bus.funct = MULTU; bus.operand_1 = a; bus.operand_2 = b; #1;
        st1 = 0;
        while (bus.stall_request && st1 < 100) begin st1++; tick(); end
        tick();
        // Divide enters EX right behind the multiply; ex_stall must not slow it.
        bus.funct = DIVU; bus.operand_1 = c; bus.operand_2 = d; bus.ex_stall = 1'b1; #1;
        checks++; if ({bus.hi, bus.lo} !== p) begin failures++; $display("FAIL b2b_mul got=%h exp=%h", {bus.hi, bus.lo}, p); end
        st2 = 0;
        while (bus.stall_request && st2 < 100) begin st2++; tick(); end
        checks++; if (st2 !== 33) begin failures++; $display("FAIL b2b_div_stalls got=%0d exp=33", st2); end
        bus.ex_stall = 1'b0;
        tick();
        bus.valid = 1'b0; bus.funct = 6'h0;
        checks++; if ({bus.hi, bus.lo} !== {r, q}) begin failures++; $display("FAIL b2b_div got=%h exp=%h", {bus.hi, bus.lo}, {r, q}); end
    endtask

    task automatic test_mt_mf();
        logic [31:0] v;
        v = $urandom;
        bus.valid = 1'b1; bus.funct = MTHI; bus.operand_1 = 32'hDEAD; tick();
        bus.funct = MFHI; #1;
        checks++; if (bus.result !== 32'hDEAD) begin failures++; $display("FAIL mfhi_after_mthi got=%h exp=%h", bus.result, 32'hDEAD); end
        bus.funct = MTLO; bus.operand_1 = v; tick();
        bus.funct = MFLO; #1;
        checks++; if (bus.result !== v) begin failures++; $display("FAIL mflo_after_mtlo got=%h exp=%h", bus.result, v); end
        bus.valid = 1'b0; #1;
        checks++; if (bus.result !== 32'h0) begin failures++; $display("FAIL mflo_invalid got=%h exp=0", bus.result); end
        bus.valid = 1'b1; bus.funct = 6'h20; #1;
        checks++; if ({bus.stall_request, bus.result} !== 33'h0) begin failures++; $display("FAIL other_funct got=%h exp=0", {bus.stall_request, bus.result}); end
        bus.valid = 1'b0; bus.funct = MTHI; bus.operand_1 = 32'hBEEF; tick();
        checks++; if (bus.hi !== 32'hDEAD) begin failures++; $display("FAIL mthi_bubble got=%h exp=%h", bus.hi, 32'hDEAD); end
        bus.funct = 6'h0;
    endtask

    task automatic test_rst_mid_mul();
        int st;
        bus.valid = 1'b1; bus.funct = MULT; bus.operand_1 = 32'h1234_5678; bus.operand_2 = 32'h9ABC_DEF0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; bus.valid = 1'b0; bus.funct = 6'h0; #1;
        checks++; if ({bus.hi, bus.lo} !== 64'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h exp=0", {bus.hi, bus.lo}); end
        checks++; if (bus.stall_request !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", bus.stall_request); end
        issue(MULTU, 32'h10, 32'h20, st);
        checks++; if (st !== 2) begin failures++; $display("FAIL rst_mid_restart got=%0d exp=2", st); end
        checks++; if ({bus.hi, bus.lo} !== 64'h200) begin failures++; $display("FAIL rst_mid_result got=%h exp=%h", {bus.hi, bus.lo}, 64'h200); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        bus.valid = 1'b0; bus.funct = 6'h0; bus.operand_1 = 32'h0; bus.operand_2 = 32'h0;
        bus.ex_stall = 1'b0; bus.flush = 1'b0;
        tick();
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_ex_stall_done();
        test_back_to_back();
        test_mt_mf();
        test_rst_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ex_muldiv.md
# ex_muldiv

EX-stage multiply/divide unit that consumes the funct and operand fields latched by the ID/EX pipeline register and owns the architectural HI/LO registers. It executes MULT/MULTU in two cycles and DIV/DIVU iteratively in 33 cycles. While busy it holds the pipeline through `stall_request` to the pipeline controller. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

## Interface
- `DATA_W`, 32: operand, HI and LO width; fixed to the data bus width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `valid`  in  1  EX holds a real instruction; low for bubbles.
- `funct`  in  6  funct field from ID/EX.
- `operand_1`  in  32  rs value, dividend or multiplicand.
- `operand_2`  in  32  rt value, divisor or multiplier.
- `ex_stall`  in  1  EX is held by another source (a downstream stall).
- `flush`  in  1  exception or ERET flush of the EX instruction.
- `stall_request`  out  1  unit needs EX held this cycle.
- `result`  out  32  MFHI/MFLO read data; 0 otherwise.
- `hi`  out  32  current HI register.
- `lo`  out  32  current LO register.

## Operation
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
  - All other codes are ignored: no stall, `result` 0.
- A start condition is `valid` & MULT/MULTU/DIV/DIVU & `!flush`.
- FSM states:
  - IDLE:
    - On a start condition, latch operands and the signed flag.
    - Go to MUL for a multiply, or to DIV with counter 0 for a divide.
  - MUL:
    - Register the 64-bit product: signed product for MULT, unsigned for MULTU.
    - Go to DONE.
  - DIV:
    - Run one restoring-division step on magnitudes per cycle.
    - After the 32nd step (counter = 31), go to DONE.
  - DONE:
    - Result is held in the result registers.
    - When `!ex_stall` & `!flush`: commit HI/LO, then go to IDLE.
    - While `ex_stall` is high: remain in DONE and do not restart.
    - On `flush`: go to IDLE with no commit.
- Any state on `flush`: go to IDLE next cycle; HI/LO are unchanged.
- `stall_request` = `valid` & mul/div funct & `!flush` & state≠DONE.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0.
  - Divide by zero gives quotient magnitude 0xFFFFFFFF and remainder = dividend magnitude, with sign fix-up applied. The software result is undefined, but the hardware result is deterministic.
- MTHI/MTLO:
  - Write `operand_1` to HI/LO on a cycle with `valid` & `!ex_stall` & `!flush` & state IDLE.
  - The write is visible to `hi`/`lo` on the next cycle.
- MFHI/MFLO: `result` is combinational from the HI/LO registers and is ignored when `!valid`.

## Timing
- Reset (`rst` low at an edge): state IDLE, HI = LO = 0, counter 0, result registers 0. `stall_request` is low the cycle after reset.
- Multiply:
  - Cycle 0 (accept) and cycle 1 (MUL) have `stall_request` high.
  - Cycle 2 is DONE with stall low.
  - HI/LO are updated at the end of cycle 2 if not stalled.
- Divide:
  - Cycle 0 (accept) and cycles 1–32 (DIV) have `stall_request` high: 33 stall cycles.
  - Cycle 33 is DONE; HI/LO commit at the end of that cycle.
- A back-to-back mul/div entering EX after DONE starts from IDLE with no bubble inside the unit.
- An MFHI immediately after a mul/div reads the committed value: commit happens at the DONE edge, and the MFHI reaches EX one cycle later.
- `ex_stall` during MUL/DIV has no effect on progress.
- `rst` or `flush` mid-divide: the counter is abandoned and no partial HI/LO write occurs.

## Structure
- Funct constants, state encodings and `DATA_W` go in a shared define header alongside `bus.v`.
- One sub-module, `div_iter`:
  - A 32-step restoring divider on unsigned magnitudes, with `start`, `busy` and `done`.
  - Outputs are `quotient` and `remainder`.
  - Sign handling, the FSM, the multiplier and HI/LO stay in `ex_muldiv`.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → stall for 2 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands → HI = 0x00000002, LO = 0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → stall for exactly 33 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 → LO = 3, HI = 1.
- DIVU 0x1234 / 0 → LO = 0xFFFFFFFF, HI = 0x1234. Signed 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- `flush` asserted at DIV cycle 10 → `stall_request` low that cycle; state IDLE next cycle; HI/LO keep their prior values (0xAAAA/0x5555).
- `ex_stall` held for 3 cycles while in DONE → no restart; HI/LO commit once, on the cycle `ex_stall` drops.
- MTHI 0xDEAD followed by MFHI → `result` = 0xDEAD. `rst` low mid-multiply → HI = LO = 0, state IDLE.
